// File: rtl/div_n8_cc8.sv
// ============================================================================
// div_n8_cc8 : constant-time restoring divider, serial dividend (MSB first)
// Rev 1.0
// ============================================================================
`default_nettype none

module div_n8_cc8 #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   g_input,
   input  logic           e_input,
   output logic [2*N-1:0] o,
   output logic           busy,
   output logic           done,
   output logic           div_by_zero
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]     state_q, state_d;
   logic [N-1:0]   d_q, d_d;
   logic [N-1:0]   r_q, r_d;
   logic [N-1:0]   q_q, q_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           z_q, z_d;
   logic [2*N-1:0] o_q, o_d;
   logic           done_q, done_d;
   logic           dbz_q, dbz_d;

   // One restoring step; the start cycle uses zeroed R/Q and the live divisor.
   logic [N-1:0]   r_in, q_in, d_cur, r_new, q_new;
   logic [N:0]     t;
   logic           ge;

   always_comb begin
      r_in  = (state_q == S_RUN) ? r_q : '0;
      q_in  = (state_q == S_RUN) ? q_q : '0;
      d_cur = (state_q == S_RUN) ? d_q : g_input;
      t     = {r_in, e_input};
      ge    = (t >= {1'b0, d_cur});
      r_new = ge ? (t[N-1:0] - d_cur) : t[N-1:0];
      q_new = {q_in[N-2:0], ge};
   end

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      r_d     = r_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      z_d     = z_q;
      o_d     = o_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               d_d   = g_input;
               z_d   = (g_input == '0);
               r_d   = r_new;
               q_d   = q_new;
               cnt_d = CW'(1);
               if (N == 1) begin
                  o_d    = {r_new, q_new};
                  dbz_d  = (g_input == '0);
                  done_d = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         default: begin
            r_d   = r_new;
            q_d   = q_new;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               state_d = S_IDLE;
               o_d     = {r_new, q_new};
               dbz_d   = z_q;
               done_d  = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         d_q     <= '0;
         r_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         z_q     <= 1'b0;
         o_q     <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         r_q     <= r_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         o_q     <= o_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign o           = o_q;
   assign busy        = (state_q == S_RUN);
   assign done        = done_q;
   assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_div_n8_cc8.sv
// Directed testbench for div_n8_cc8 (N=8): serial dividend, parallel divisor.
`default_nettype none

module tb_div_n8_cc8;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  g_input;
   logic        e_input;
   logic [15:0] o;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   int checks   = 0;
   int failures = 0;
   logic [15:0] hold_o;
   logic        hold_z;

   div_n8_cc8 #(.N(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .g_input     (g_input),
      .e_input     (e_input),
      .o           (o),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full operation. Start is accepted at the first edge; during RUN the bench
   // scrambles g_input and optionally re-pulses start at cycle T+3.
   task automatic run_op(input logic [7:0] dvs, input logic [7:0] dvd,
                         input logic [15:0] exp_o, input logic exp_z,
                         input logic repulse, input string name);
      start   = 1'b1;
      g_input = dvs;
      e_input = dvd[7];
      tick();
      for (int k = 0; k < 7; k++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s run_flags k=%0d busy=%b done=%b required busy=1 done=0",
                     name, k, busy, done);
         end
         checks++;
         if (o !== hold_o || div_by_zero !== hold_z) begin
            failures++;
            $display("FAIL %s hold k=%0d o=%h dbz=%b required o=%h dbz=%b",
                     name, k, o, div_by_zero, hold_o, hold_z);
         end
         start   = (repulse && k == 2);
         g_input = (repulse && k == 2) ? 8'h03 : 8'($urandom);
         e_input = dvd[6-k];
         tick();
      end
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || o !== exp_o || div_by_zero !== exp_z) begin
         failures++;
         $display("FAIL %s result done=%b busy=%b o=%h dbz=%b required done=1 busy=0 o=%h dbz=%b",
                  name, done, busy, o, div_by_zero, exp_o, exp_z);
      end
      hold_o = exp_o;
      hold_z = exp_z;
   endtask

   task automatic idle_check(input string name);
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || o !== hold_o || div_by_zero !== hold_z) begin
         failures++;
         $display("FAIL %s idle done=%b busy=%b o=%h dbz=%b required done=0 busy=0 o=%h dbz=%b",
                  name, done, busy, o, div_by_zero, hold_o, hold_z);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; g_input = 8'h00; e_input = 1'b0;
      tick(); tick();
      checks++;
      if (o !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
         failures++;
         $display("FAIL reset_state o=%h busy=%b done=%b dbz=%b required all zero",
                  o, busy, done, div_by_zero);
      end
      rst = 1'b0;
      hold_o = 16'h0000;
      hold_z = 1'b0;
   endtask

   task automatic test_basic();
      run_op(8'd7,   8'hC8, 16'h041C, 1'b0, 1'b0, "div_200_7");
      idle_check("after_200_7");
      run_op(8'd1,   8'hFF, 16'h00FF, 1'b0, 1'b0, "div_255_1");
      run_op(8'd9,   8'h05, 16'h0500, 1'b0, 1'b0, "div_5_9");
      run_op(8'hFF,  8'hFF, 16'h0001, 1'b0, 1'b0, "div_255_255");
      idle_check("after_255_255");
   endtask

   task automatic test_div_zero();
      run_op(8'd0, 8'hA5, 16'hA5FF, 1'b1, 1'b0, "div_by_zero");
      idle_check("after_dbz");
      run_op(8'd3, 8'd9,  16'h0003, 1'b0, 1'b0, "div_9_3_after_dbz");
   endtask

   task automatic test_back_to_back();
      run_op(8'd7,  8'hC8,  16'h041C, 1'b0, 1'b0, "b2b_first");
      run_op(8'd10, 8'd100, 16'h000A, 1'b0, 1'b0, "b2b_second");
      idle_check("after_b2b");
   endtask

   task automatic test_start_ignored();
      run_op(8'd7, 8'hC8, 16'h041C, 1'b0, 1'b1, "repulse_200_7");
      idle_check("after_repulse");
   endtask

   task automatic test_reset_mid_op();
      logic [7:0] dvd;
      dvd = 8'hC8;
      start = 1'b1; g_input = 8'd7; e_input = dvd[7];
      tick();
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         e_input = dvd[6-k];
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || o !== 16'h0000 || done !== 1'b0 || div_by_zero !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_op busy=%b o=%h done=%b dbz=%b required busy=0 o=0000 done=0 dbz=0",
                  busy, o, done, div_by_zero);
      end
      hold_o = 16'h0000;
      hold_z = 1'b0;
      for (int k = 0; k < 10; k++) begin
         e_input = k[0];
         idle_check("no_done_after_abort");
      end
      run_op(8'd7, 8'hC8, 16'h041C, 1'b0, 1'b0, "after_abort_200_7");
   endtask

   task automatic test_random();
      logic [7:0] a, b;
      for (int i = 0; i < 200; i++) begin
         a = 8'($urandom);
         b = 8'($urandom_range(1, 255));
         run_op(b, a, {a % b, a / b}, 1'b0, 1'b0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_back_to_back();
      test_start_ignored();
      test_reset_mid_op();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
